// File: rtl/mdio_responder_pkg.sv
// Shared MDIO definitions: one-hot responder states, opcodes and frame bit positions.
// The controller side imports the same package so both ends agree on framing.
package mdio_responder_pkg;

   typedef enum logic [6:0] {
      ST_IDLE    = 7'b0000001,
      ST_START   = 7'b0000010,
      ST_HEADER  = 7'b0000100,
      ST_TURN    = 7'b0001000,
      ST_WR_DATA = 7'b0010000,
      ST_RD_DATA = 7'b0100000,
      ST_SKIP    = 7'b1000000
   } state_t;

   localparam logic [1:0] OP_WR = 2'b01;
   localparam logic [1:0] OP_RD = 2'b10;

   // 1-based bit numbers within the 32-bit frame
   localparam logic [5:0] BIT_REGAD_END = 6'd14;
   localparam logic [5:0] BIT_TA_FIRST  = 6'd15;
   localparam logic [5:0] BIT_TA_END    = 6'd16;
   localparam logic [5:0] BIT_LAST      = 6'd32;

   function automatic logic op_valid(input logic [1:0] op);
      return (op == OP_WR) || (op == OP_RD);
   endfunction

endpackage

// File: rtl/mdc_edge_det.sv
// Flags the clk cycle in which mdc is high and was low on the previous clk.
// Combinational output, one register of history.
module mdc_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic mdc,
   output logic rise
);
   logic r_mdc_prev;

   always_ff @(posedge clk) begin
      if (rst) r_mdc_prev <= 1'b0;
      else     r_mdc_prev <= mdc;
   end

   assign rise = mdc & ~r_mdc_prev;

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: decodes frames sampled on MDC rise, strobes register reads/writes,
// and drives read data back one clk after each sampling edge.
module mdio_responder
   import mdio_responder_pkg::*;
#(
   parameter logic [4:0] PHY_ADDR = 5'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mdc,
   input  logic        mdio_out,
   input  logic [15:0] rd_data,
   output logic        mdio_in,
   output logic        mdio_oe,
   output logic [4:0]  addr,
   output logic [15:0] wr_data,
   output logic        wr_stb,
   output logic        rd_stb
);
   logic        w_rise;
   state_t      r_state, w_state_nxt;
   logic [5:0]  r_cnt, w_cnt_inc;
   logic [11:0] r_hdr, w_hdr, w_hdr_nxt;
   logic        r_is_rd, w_is_rd_nxt;
   logic [15:0] r_rd_sh, w_rd_sh_nxt;
   logic        w_match;
   logic        w_oe_nxt, w_in_nxt, w_wr_stb_nxt, w_rd_stb_nxt;
   logic [4:0]  w_addr_nxt;
   logic [15:0] w_wr_data_nxt;

   mdc_edge_det u_edge (
      .clk  (clk),
      .rst  (rst),
      .mdc  (mdc),
      .rise (w_rise)
   );

   assign w_cnt_inc = (r_cnt == BIT_LAST) ? BIT_LAST : r_cnt + 6'd1;
   assign w_hdr     = {r_hdr[10:0], mdio_out};
   assign w_match   = op_valid(w_hdr[11:10]) && (w_hdr[9:5] == PHY_ADDR);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_hdr   <= '0;
         r_is_rd <= 1'b0;
         r_rd_sh <= '0;
         mdio_in <= 1'b0;
         mdio_oe <= 1'b0;
         addr    <= '0;
         wr_data <= '0;
         wr_stb  <= 1'b0;
         rd_stb  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // START absorbs repeated 0s without advancing the bit count
         if (w_rise) begin
            if (w_state_nxt == ST_IDLE)
               r_cnt <= '0;
            else if (!(r_state == ST_START && !mdio_out))
               r_cnt <= w_cnt_inc;
         end
         r_hdr   <= w_hdr_nxt;
         r_is_rd <= w_is_rd_nxt;
         r_rd_sh <= w_rd_sh_nxt;
         mdio_in <= w_in_nxt;
         mdio_oe <= w_oe_nxt;
         addr    <= w_addr_nxt;
         wr_data <= w_wr_data_nxt;
         wr_stb  <= w_wr_stb_nxt;
         rd_stb  <= w_rd_stb_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_rise) begin
         case (r_state)
            ST_IDLE:   if (!mdio_out) w_state_nxt = ST_START;
            ST_START:  if (mdio_out)  w_state_nxt = ST_HEADER;
            ST_HEADER: if (w_cnt_inc == BIT_REGAD_END)
                          w_state_nxt = w_match ? ST_TURN : ST_SKIP;
            ST_TURN:   if (w_cnt_inc == BIT_TA_END)
                          w_state_nxt = r_is_rd ? ST_RD_DATA : ST_WR_DATA;
            ST_WR_DATA, ST_RD_DATA, ST_SKIP:
                       if (w_cnt_inc == BIT_LAST) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_hdr_nxt     = r_hdr;
      w_is_rd_nxt   = r_is_rd;
      w_rd_sh_nxt   = r_rd_sh;
      w_in_nxt      = mdio_in;
      w_oe_nxt      = mdio_oe;
      w_addr_nxt    = addr;
      w_wr_data_nxt = wr_data;
      w_wr_stb_nxt  = 1'b0;
      w_rd_stb_nxt  = 1'b0;
      // register file answers during the rd_stb cycle
      if (rd_stb) w_rd_sh_nxt = rd_data;
      if (w_rise) begin
         case (r_state)
            ST_HEADER: begin
               w_hdr_nxt = w_hdr;
               if (w_cnt_inc == BIT_REGAD_END && w_match) begin
                  w_addr_nxt   = w_hdr[4:0];
                  w_is_rd_nxt  = (w_hdr[11:10] == OP_RD);
                  w_rd_stb_nxt = (w_hdr[11:10] == OP_RD);
               end
            end
            ST_TURN: if (r_is_rd) begin
               w_oe_nxt = 1'b1;
               if (w_cnt_inc == BIT_TA_FIRST) begin
                  w_in_nxt = 1'b0;
               end else begin
                  w_in_nxt    = r_rd_sh[15];
                  w_rd_sh_nxt = {r_rd_sh[14:0], 1'b0};
               end
            end
            ST_RD_DATA: begin
               if (w_cnt_inc == BIT_LAST) begin
                  w_oe_nxt = 1'b0;
                  w_in_nxt = 1'b0;
               end else begin
                  w_in_nxt    = r_rd_sh[15];
                  w_rd_sh_nxt = {r_rd_sh[14:0], 1'b0};
               end
            end
            ST_WR_DATA: begin
               w_wr_data_nxt = {wr_data[14:0], mdio_out};
               if (w_cnt_inc == BIT_LAST) w_wr_stb_nxt = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
